i2c_respond: RTL and testbench



---
 rtl/i2c_respond_if.sv | 22 ++
 rtl/i2c_respond.sv | 125 ++++++++++++
 tb/tb_i2c_respond.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_respond_if.sv
// i2c_respond_if: pad levels, core-side shadow write port and the forwarded byte stream of the I2C responder.
interface i2c_respond_if #(parameter int REG_AW = 4);
    logic scl_in;
    logic sda_in;
    logic sda_oe;
    logic shadow_we;
    logic [REG_AW-1:0] shadow_addr;
    logic [7:0] shadow_wdata;
    logic [8:0] word;
    logic word_ready;
    logic reg_wr;
    logic [REG_AW-1:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    modport slave(
        input scl_in, sda_in, shadow_we, shadow_addr, shadow_wdata,
        output sda_oe, word, word_ready, reg_wr, reg_wr_addr, reg_wr_data
    );
    modport master(
        output scl_in, sda_in, shadow_we, shadow_addr, shadow_wdata,
        input sda_oe, word, word_ready, reg_wr, reg_wr_addr, reg_wr_data
    );
endinterface

// File: rtl/i2c_respond.sv
// i2c_respond: I2C target standing in for the PMIC; shadow register file plus a byte stream for the matcher.
// Define I2C_RESP_READ_EN to serve read transfers; without it an address byte with R/W = 1 is NACKed.
module i2c_respond #(
    parameter logic [6:0] DEV_ADDR = 7'h4A,
    parameter int REG_AW = 4
) (
    input logic clk,
    input logic reset,
    i2c_respond_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, PTR, WDATA, RDATA, IGNORE} state_t;
    state_t state;
    logic [1:0] scl_s, sda_s;
    logic scl_d, sda_d, rise, fall, start, stop, sda_smp;
    logic [3:0] bit_cnt;
    logic [7:0] rx, rx_next;
    logic [REG_AW-1:0] ptr;
    logic [7:0] shadow [2**REG_AW];
    logic addr_hit;
    assign rx_next = {rx[6:0], sda_smp};
`ifdef I2C_RESP_READ_EN
    logic [7:0] tx, rd_byte;
    assign rd_byte = shadow[ptr];
    assign addr_hit = rx_next[7:1] == DEV_ADDR;
`else
    assign addr_hit = rx_next[7:1] == DEV_ADDR && !rx_next[0];
`endif
    // Synchronizers idle high so reset release never fakes a START or SCL edge.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            scl_s <= 2'b11;
            sda_s <= 2'b11;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
            rise <= 1'b0;
            fall <= 1'b0;
            start <= 1'b0;
            stop <= 1'b0;
            sda_smp <= 1'b1;
        end else begin
            scl_s <= {scl_s[0], bus.scl_in};
            sda_s <= {sda_s[0], bus.sda_in};
            scl_d <= scl_s[1];
            sda_d <= sda_s[1];
            rise <= scl_s[1] & ~scl_d;
            fall <= ~scl_s[1] & scl_d;
            start <= scl_s[1] & scl_d & sda_d & ~sda_s[1];
            stop <= scl_s[1] & scl_d & ~sda_d & sda_s[1];
            sda_smp <= sda_s[1];
        end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            bit_cnt <= '0;
            rx <= '0;
            ptr <= '0;
            shadow <= '{default: '0};
            bus.sda_oe <= 1'b0;
            bus.word <= 9'h1FF;
            bus.word_ready <= 1'b0;
            bus.reg_wr <= 1'b0;
            bus.reg_wr_addr <= '0;
            bus.reg_wr_data <= '0;
`ifdef I2C_RESP_READ_EN
            tx <= '0;
`endif
        end else begin
            bus.word_ready <= 1'b0;
            bus.reg_wr <= 1'b0;
            // Core write first so a same-entry bus write below overrides it.
            if (bus.shadow_we)
                shadow[bus.shadow_addr] <= bus.shadow_wdata;
            if (start) begin
                state <= ADDR;
                bit_cnt <= '0;
                bus.sda_oe <= 1'b0;
            end else if (stop) begin
                state <= IDLE;
                bus.sda_oe <= 1'b0;
            end else if (fall && state != IDLE) begin
`ifdef I2C_RESP_READ_EN
                if (state == RDATA) begin
                    bus.sda_oe <= bit_cnt == 4'd0 ? ~rd_byte[7] : bit_cnt != 4'd8 && ~tx[7];
                    tx <= bit_cnt == 4'd0 ? {rd_byte[6:0], 1'b0} : {tx[6:0], 1'b0};
                end else
`endif
                bus.sda_oe <= bit_cnt == 4'd8 && (state == ADDR_ACK || state == PTR || state == WDATA);
            end else if (rise && state != IDLE) begin
                if (bit_cnt != 4'd8) begin
                    rx <= rx_next;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (state == ADDR && bit_cnt == 4'd7)
                        state <= addr_hit ? ADDR_ACK : IGNORE;
                end else begin
                    bit_cnt <= '0;
                    bus.word <= {rx, sda_smp};
                    bus.word_ready <= 1'b1;
                    case (state)
`ifdef I2C_RESP_READ_EN
                        ADDR_ACK: state <= rx[0] ? RDATA : PTR;
                        RDATA: begin
                            ptr <= ptr + 1'b1;
                            if (sda_smp)
                                state <= IGNORE;
                        end
`else
                        ADDR_ACK: state <= PTR;
`endif
                        PTR: begin
                            ptr <= rx[REG_AW-1:0];
                            state <= WDATA;
                        end
                        WDATA: begin
                            shadow[ptr] <= rx;
                            bus.reg_wr <= 1'b1;
                            bus.reg_wr_addr <= ptr;
                            bus.reg_wr_data <= rx;
                            ptr <= ptr + 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
endmodule

// File: tb/tb_i2c_respond.sv
// tb_i2c_respond: bench-side I2C master with random traffic, checked against a transaction-level model.
module tb_i2c_respond;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [7:0] m_shadow [16];
    logic [3:0] m_ptr;
    logic [8:0] exp_words[$];
    logic [8:0] seen_words[$];
    logic [11:0] exp_wr[$];
    logic [11:0] wr_log[$];
    logic [7:0] rd_log[$];
    logic [7:0] wq[$];
    bit oe_seen;

    i2c_respond_if #(.REG_AW(4)) bus();
    i2c_respond dut(.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Every emitted word and register write is matched in order against the model's queues.
    always @(negedge clk) begin
        if (bus.sda_oe)
            oe_seen = 1'b1;
        if (bus.word_ready) begin
            seen_words.push_back(bus.word);
            if (exp_words.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL word_extra: got %0h, no word expected", bus.word);
            end else
                check("word", bus.word, exp_words.pop_front());
        end
        if (bus.reg_wr) begin
            wr_log.push_back({bus.reg_wr_addr, bus.reg_wr_data});
            check("reg_wr_with_word", bus.word_ready, 1);
            if (exp_wr.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL reg_wr_extra: got %0h, no write expected", {bus.reg_wr_addr, bus.reg_wr_data});
            end else
                check("reg_wr", {bus.reg_wr_addr, bus.reg_wr_data}, exp_wr.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period; coll pulses shadow_we exactly on the cycle the DUT acts on this rising edge.
    task automatic put_bit(input logic b, output logic got, input bit coll = 1'b0);
        sda_m = b;
        tick(5);
        scl_m = 1'b1;
        if (coll) begin
            tick(3);
            bus.shadow_we = 1'b1;
            tick(1);
            bus.shadow_we = 1'b0;
            tick(1);
        end else
            tick(5);
        got = bus.sda_in;
        tick(5);
        scl_m = 1'b0;
        tick(5);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1;
        tick(5);
        scl_m = 1'b1;
        tick(10);
        sda_m = 1'b0;
        tick(10);
        scl_m = 1'b0;
        tick(5);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0;
        tick(5);
        scl_m = 1'b1;
        tick(10);
        sda_m = 1'b1;
        tick(10);
    endtask

    task automatic core_write(input logic [3:0] a, input logic [7:0] d);
        bus.shadow_addr = a;
        bus.shadow_wdata = d;
        bus.shadow_we = 1'b1;
        tick(1);
        bus.shadow_we = 1'b0;
        m_shadow[a] = d;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ea, input string name, input bit coll = 1'b0);
        logic g;
        for (int i = 7; i >= 0; i--)
            put_bit(b[i], g);
        exp_words.push_back({b, ea});
        put_bit(1'b1, g, coll);
        check(name, g, ea);
    endtask

    task automatic wr_txn(input logic [7:0] p, input bit do_stop, input int coll_at = -1,
                          input logic [3:0] ca = 4'd0, input logic [7:0] cd = 8'd0);
        i2c_start;
        send_byte(8'h94, 1'b0, "addr_ack");
        send_byte(p, 1'b0, "ptr_ack");
        m_ptr = p[3:0];
        foreach (wq[i]) begin
            exp_wr.push_back({m_ptr, wq[i]});
            if (i == coll_at) begin
                bus.shadow_addr = ca;
                bus.shadow_wdata = cd;
                m_shadow[ca] = cd;
            end
            m_shadow[m_ptr] = wq[i];
            send_byte(wq[i], 1'b0, "data_ack", i == coll_at);
            m_ptr++;
        end
        if (do_stop)
            i2c_stop;
    endtask

`ifdef I2C_RESP_READ_EN
    task automatic recv_byte(input logic [7:0] e, input logic mack, input bit inflight, output logic [7:0] v);
        logic g;
        for (int i = 7; i >= 0; i--) begin
            put_bit(1'b1, g);
            v[i] = g;
            if (inflight && i == 4)
                core_write(m_ptr, ~m_shadow[m_ptr]);
        end
        exp_words.push_back({e, mack});
        put_bit(mack, g);
        check("rdata", v, e);
    endtask

    task automatic rd_txn(input int n, input bit inflight = 1'b0);
        logic [7:0] v;
        i2c_start;
        send_byte(8'h95, 1'b0, "rd_addr_ack");
        for (int i = 0; i < n; i++) begin
            recv_byte(m_shadow[m_ptr], i == n - 1, inflight && i == 0, v);
            rd_log.push_back(v);
            m_ptr++;
        end
        i2c_stop;
    endtask
`else
    task automatic rd_txn;
        i2c_start;
        send_byte(8'h95, 1'b1, "rd_addr_nack");
        i2c_stop;
    endtask
`endif

    task automatic foreign(input logic [7:0] b, input int extra);
        oe_seen = 1'b0;
        i2c_start;
        send_byte(b, 1'b1, "foreign_nack");
        for (int i = 0; i < extra; i++)
            send_byte(8'($urandom), 1'b1, "foreign_data_nack");
        i2c_stop;
        check("foreign_oe_quiet", oe_seen, 0);
    endtask

    initial begin
        int n0, n1;
        logic [7:0] f, a;
        logic g;
        bus.shadow_we = 1'b0;
        bus.shadow_addr = '0;
        bus.shadow_wdata = '0;
        foreach (m_shadow[i])
            m_shadow[i] = 8'h00;
        m_ptr = 4'd0;
        tick(3);
        check("rst_sda_oe", bus.sda_oe, 0);
        check("rst_word", bus.word, 9'h1FF);
        check("rst_word_ready", bus.word_ready, 0);
        check("rst_reg_wr", bus.reg_wr, 0);
        check("rst_reg_wr_addr", bus.reg_wr_addr, 0);
        check("rst_reg_wr_data", bus.reg_wr_data, 0);
        reset = 1'b0;
        tick(5);

        n0 = seen_words.size();
        n1 = wr_log.size();
        wq = {};
        wq.push_back(8'hA7);
        wr_txn(8'h05, 1'b1);
        check("seq_word0", seen_words[n0], 9'h128);
        check("seq_word1", seen_words[n0 + 1], 9'h00A);
        check("seq_word2", seen_words[n0 + 2], 9'h14E);
        check("seq_reg_wr", wr_log[n1], {4'd5, 8'hA7});

        n0 = seen_words.size();
        wq = {};
        wr_txn(8'h05, 1'b0);
`ifdef I2C_RESP_READ_EN
        n1 = rd_log.size();
        rd_txn(2);
        check("readback_a7", rd_log[n1], 8'hA7);
        check("readback_sh6", rd_log[n1 + 1], 8'h00);
        core_write(4'd7, 8'h3C);
        rd_txn(1);
        check("ptr_at_7", rd_log[n1 + 2], 8'h3C);
`else
        rd_txn;
        check("rd_nack_word", seen_words[n0 + 2], 9'h12B);
`endif

        n0 = seen_words.size();
        foreign(8'h40, 1);
        check("foreign_word", seen_words[n0], 9'h081);

        n1 = wr_log.size();
        wq = {};
        wq.push_back(8'h11);
        wq.push_back(8'h22);
        wr_txn(8'h0F, 1'b1);
        check("wrap_wr0", wr_log[n1], {4'hF, 8'h11});
        check("wrap_wr1", wr_log[n1 + 1], {4'h0, 8'h22});

        wq = {};
        wq.push_back(8'h66);
        wr_txn(8'h03, 1'b1, 0, 4'd3, 8'h55);
        wq = {};
        wq.push_back(8'h77);
        wr_txn(8'h04, 1'b1, 0, 4'd9, 8'h5A);
`ifdef I2C_RESP_READ_EN
        n1 = rd_log.size();
        wq = {};
        wr_txn(8'h0F, 1'b0);
        rd_txn(2);
        check("wrap_sh15", rd_log[n1], 8'h11);
        check("wrap_sh0", rd_log[n1 + 1], 8'h22);
        wr_txn(8'h03, 1'b0);
        rd_txn(1);
        check("collide_same", rd_log[n1 + 2], 8'h66);
        wr_txn(8'h09, 1'b0);
        rd_txn(1, 1'b1);
        check("collide_other", rd_log[n1 + 3], 8'h5A);
`endif

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0: core_write(4'($urandom), 8'($urandom));
                1, 2: begin
                    wq = {};
                    repeat ($urandom_range(1, 4))
                        wq.push_back(8'($urandom));
                    wr_txn(8'($urandom), 1'b1);
                end
                3: begin
                    do
                        f = 8'($urandom);
                    while (f[7:1] == 7'h4A);
                    foreign(f, $urandom_range(0, 2));
                end
                default: begin
                    wq = {};
                    wr_txn(8'($urandom), 1'b0);
`ifdef I2C_RESP_READ_EN
                    rd_txn($urandom_range(1, 3), 1'($urandom));
`else
                    rd_txn;
`endif
                end
            endcase
        end
        tick(20);
        check("words_drained", exp_words.size(), 0);
        check("writes_drained", exp_wr.size(), 0);

        // Reset while the address ACK is being driven.
        a = 8'h94;
        i2c_start;
        for (int i = 7; i >= 0; i--)
            put_bit(a[i], g);
        sda_m = 1'b1;
        tick(1);
        check("ack_before_reset", bus.sda_oe, 1);
        #2 reset = 1'b1;
        #1;
        check("reset_async_oe", bus.sda_oe, 0);
        check("reset_word", bus.word, 9'h1FF);
        tick(3);
        reset = 1'b0;
        foreach (m_shadow[i])
            m_shadow[i] = 8'h00;
        m_ptr = 4'd0;
        tick(5);
        for (int i = 7; i >= 0; i--)
            put_bit(a[i], g);
        put_bit(1'b1, g);
        check("idle_after_reset", g, 1);
        i2c_stop;
        wq = {};
        wq.push_back(8'h5C);
        wr_txn(8'h02, 1'b1);
`ifdef I2C_RESP_READ_EN
        n1 = rd_log.size();
        wq = {};
        wr_txn(8'h00, 1'b0);
        rd_txn(1);
        check("shadow_cleared", rd_log[n1], 8'h00);
`endif
        tick(20);
        check("final_words_drained", exp_words.size(), 0);
        check("final_writes_drained", exp_wr.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
